uart_mem_dumper: RTL and testbench



---
 rtl/uart_mem_dumper_pkg.sv | 23 ++
 rtl/uart_mem_dumper_tx.sv | 58 +++++
 rtl/uart_mem_dumper.sv | 118 +++++++++++
 tb/tb_uart_mem_dumper.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_dumper_pkg.sv
// Shared definitions for the UART memory dumper: FSM encoding, 8N1 frame
// constants and the baud divider derivation.
package uart_mem_dumper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    NEXT,
    DONE
  } state_e;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  function automatic int clks_per_bit(input int sys_clk_freq, input int baud);
    return sys_clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_mem_dumper_tx.sv
// 8N1 UART transmitter with a valid/ready byte input; each bit is held for
// CLKS_PER_BIT cycles and ready stays low until the stop bit has completed.
module uart_tx_serializer
  import uart_mem_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 ready_o,
  output logic                 tx_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(FRAME_BITS);

  logic [CW-1:0]                  baud_q;
  logic [BW-1:0]                  bit_q;
  logic [DATA_BITS+STOP_BITS-1:0] shift_q;
  logic                           busy_q;
  logic                           tx_q;

  assign ready_o = ~busy_q;
  assign tx_o    = tx_q;

  // bit_q: 0 = start bit, 1..DATA_BITS = data, last = stop bit
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      busy_q <= 1'b0;
      tx_q   <= IDLE_LEVEL;
      baud_q <= '0;
      bit_q  <= '0;
    end else if (!busy_q) begin
      if (valid_i) begin
        busy_q  <= 1'b1;
        tx_q    <= ~IDLE_LEVEL;
        shift_q <= {{STOP_BITS{IDLE_LEVEL}}, data_i};
        baud_q  <= '0;
        bit_q   <= '0;
      end
    end else if (baud_q == CW'(CLKS_PER_BIT - 1)) begin
      baud_q <= '0;
      if (bit_q == BW'(FRAME_BITS - 1)) begin
        busy_q <= 1'b0;
        tx_q   <= IDLE_LEVEL;
      end else begin
        tx_q    <= shift_q[0];
        shift_q <= {IDLE_LEVEL, shift_q[DATA_BITS+STOP_BITS-1:1]};
        bit_q   <= bit_q + 1'b1;
      end
    end else begin
      baud_q <= baud_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_mem_dumper.sv
// Streams a range of 32-bit words from a synchronous-read SRAM port out of a
// UART TX pin, least-significant byte first.
module uart_mem_dumper
  import uart_mem_dumper_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 60000000,
  parameter int BAUD         = 9600,
  parameter int ADDR_WIDTH   = 13
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  output logic                  mem_csb_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_data_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK_FREQ, BAUD);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic [31:0]           word_q;
  logic [1:0]            idx_q;
  logic                  csb_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_BITS-1:0]  tx_byte;

  assign cnt_d      = cnt_q - 1'b1;
  assign tx_valid   = (state_q == SEND);
  assign tx_byte    = word_q[{idx_q, 3'b000} +: DATA_BITS];
  assign mem_csb_o  = csb_q;
  assign mem_addr_o = addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      csb_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      csb_q  <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q <= base_addr_i;
            cnt_q  <= word_count_i;
            busy_q <= 1'b1;
            if (word_count_i == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= READ;
              csb_q   <= 1'b0;
            end
          end
        end
        READ:  state_q <= LATCH;
        LATCH: begin
          word_q  <= mem_data_i;
          idx_q   <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) state_q <= NEXT;
          end
        end
        NEXT: begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_d;
          if (cnt_d == '0) begin
            state_q <= DONE;
          end else begin
            state_q <= READ;
            csb_q   <= 1'b0;
          end
        end
        // completion is reported once the final stop bit has left the pin
        DONE: begin
          if (tx_ready) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .valid_i(tx_valid),
    .data_i (tx_byte),
    .ready_o(tx_ready),
    .tx_o   (tx_o)
  );

endmodule

// File: tb/tb_uart_mem_dumper.sv
// Directed and randomized bench for uart_mem_dumper: a UART receiver decodes
// tx_o and compares every frame with bytes derived from the memory image.
module tb_uart_mem_dumper;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   cnt = '0;
  logic          csb;
  logic [AW-1:0] maddr;
  logic [31:0]   mdata;
  logic          tx;
  logic          busy;
  logic          done;

  logic [31:0] mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          exp_addr[$];
  int          rd_q[$];
  int          frames = 0;
  int          dones = 0;

  always #5 clk = ~clk;

  uart_mem_dumper #(
    .SYS_CLK_FREQ(40),
    .BAUD        (4),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst_n),
    .start_i     (start),
    .base_addr_i (base),
    .word_count_i(cnt),
    .mem_csb_o   (csb),
    .mem_addr_o  (maddr),
    .mem_data_i  (mdata),
    .tx_o        (tx),
    .busy_o      (busy),
    .done_o      (done)
  );

  always @(posedge clk) if (!csb) mdata <= mem[maddr];

  // UART receiver, read-port and done observer, all sampled on the falling edge
  logic        prev_csb = 1'b1;
  logic        rx_active = 1'b0;
  int          rx_idx = 0;
  int          gap = 0;
  logic        b2b = 1'b0;
  logic [99:0] wave;
  always @(negedge clk) begin : mon
    logic [99:0] ideal;
    logic [7:0]  want;
    logic [7:0]  got;
    logic        had;
    if (!csb) begin
      rd_q.push_back(int'(maddr));
      checks++;
      assert (prev_csb === 1'b1)
      else begin errors++; $error("FAIL csb_one_cycle got=%b want=1", prev_csb); end
    end
    prev_csb = csb;
    if (done === 1'b1) dones++;
    if (!rst_n) begin
      rx_active = 1'b0;
      rx_idx = 0;
      gap = 0;
      b2b = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        if (b2b) begin
          checks++;
          assert (gap <= 1)
          else begin errors++; $error("FAIL frame_gap got=%0d want<=1", gap); end
        end
        b2b = 1'b0;
        rx_active = 1'b1;
        rx_idx = 0;
        wave = '0;
        wave[0] = tx;
      end else begin
        gap++;
      end
    end else begin
      rx_idx++;
      wave[rx_idx] = tx;
      if (rx_idx == 99) begin
        rx_active = 1'b0;
        gap = 0;
        had = (exp_q.size() > 0);
        want = had ? exp_q.pop_front() : 8'h00;
        for (int i = 0; i < 100; i++)
          ideal[i] = (i < 10) ? 1'b0 : (i < 90) ? want[(i - 10) / 10] : 1'b1;
        for (int k = 0; k < 8; k++) got[k] = wave[15 + 10 * k];
        frames++;
        checks++;
        assert (had && wave === ideal)
        else begin
          errors++;
          $error("FAIL frame got=%02h want=%02h expected_frame=%0d wave=%h", got, want, had, wave);
        end
        b2b = (exp_q.size() > 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin errors++; $error("FAIL %s got=%0h want=%0h", tag, got, want); end
  endtask

  task automatic expect_dump(input int b, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = mem[(b + i) % DEPTH];
      for (int k = 0; k < 4; k++) exp_q.push_back(w[8 * k +: 8]);
      exp_addr.push_back((b + i) % DEPTH);
    end
  endtask

  task automatic run_dump(input int b, input int n, input string tag, input int mid = -1);
    int   cyc;
    int   f0;
    int   d0;
    int   budget;
    logic busy_drop;
    exp_addr.delete();
    rd_q.delete();
    expect_dump(b, n);
    f0 = frames;
    d0 = dones;
    budget = 500 * n + 50;
    busy_drop = 1'b0;
    start = 1'b1;
    base = AW'(b);
    cnt = (AW + 1)'(n);
    tick();
    start = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      if (cyc == mid) begin
        start = 1'b1;
        base = AW'(b + 3);
        cnt = (AW + 1)'(3);
      end
      tick();
      start = 1'b0;
      if (done !== 1'b1 && busy !== 1'b1) busy_drop = 1'b1;
      cyc++;
    end
    chk({tag, " done_seen"}, done, 1);
    chk({tag, " busy_held"}, busy_drop, 0);
    chk({tag, " busy_at_done"}, busy, 0);
    if (n == 0) chk({tag, " done_latency"}, cyc, 1);
    tick();
    chk({tag, " done_single"}, done, 0);
    chk({tag, " done_count"}, dones - d0, 1);
    chk({tag, " frames"}, frames - f0, 4 * n);
    chk({tag, " bytes_left"}, exp_q.size(), 0);
    chk({tag, " tx_idle"}, tx, 1);
    chk({tag, " n_reads"}, rd_q.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < rd_q.size(); i++)
      chk({tag, " rd_addr"}, rd_q[i], exp_addr[i]);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int f0;
    int cyc;
    int b;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst tx", tx, 1);
    chk("rst csb", csb, 1);
    chk("rst addr", maddr, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    rst_n = 1'b1;
    tick();

    mem[5] = 32'h44332211;
    run_dump(5, 1, "single");

    run_dump(3, 0, "zero");

    mem[7] = 32'hA5A5A5A5;
    mem[0] = 32'h0000005A;
    run_dump(7, 2, "wrap");

    run_dump(2, 1, "mid_start", 150);
    f0 = frames;
    repeat (300) tick();
    chk("mid_start no_queue_busy", busy, 0);
    chk("mid_start no_queue_frames", frames - f0, 0);

    // reset while bit 3 of the second byte is on the line
    b = $urandom_range(0, DEPTH - 1);
    exp_addr.delete();
    expect_dump(b, 1);
    f0 = frames;
    start = 1'b1;
    base = AW'(b);
    cnt = (AW + 1)'(1);
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(frames == f0 + 1 && rx_active && rx_idx == 44) && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("reset_mid reached_bit3", cyc < 400, 1);
    rst_n = 1'b0;
    tick();
    chk("reset_mid tx", tx, 1);
    chk("reset_mid busy", busy, 0);
    chk("reset_mid csb", csb, 1);
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    run_dump(b, 1, "after_reset");

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    run_dump($urandom_range(0, DEPTH - 1), 3, "b2b3");
    run_dump($urandom_range(0, DEPTH - 1), DEPTH, "full");
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      run_dump($urandom_range(0, DEPTH - 1), $urandom_range(1, 3), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
